fpu_issue_ctrl: RTL and testbench

- Sequencer in front of the FPU top (add/sub/mul/div, 2-bit op select, valid/ready).
- Accepts tagged operation requests through a valid/ready handshake and buffers them in a small FIFO.
- Issues one operation at a time to the FPU, holding operands and op select stable until the FPU answers.
- Returns the result with its tag through a valid/ready response handshake. A timeout watchdog guarantees forward progress.

---
 rtl/fpu_ctrl_pkg.sv | 30 +++
 rtl/fpu_req_fifo.sv | 64 ++++++
 rtl/fpu_issue_ctrl.sv | 153 +++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_ctrl_pkg.sv
// Shared types for the FPU issue controller: op codes, FSM states and the request record.
package fpu_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    localparam int unsigned DEF_TAG_W = 4;

    // Default request record; the top rebuilds it with its own TAG_W.
    typedef struct packed {
        op_e                  op;
        logic [31:0]          a;
        logic [31:0]          b;
        logic [DEF_TAG_W-1:0] tag;
    } req_t;

endpackage

// File: rtl/fpu_req_fifo.sv
// Request FIFO: DEPTH entries (power of 2), pointers wrap naturally, occupancy exported.
module fpu_req_fifo
    import fpu_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = req_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  T                       i_data,
    input  logic                   i_pop,
    output T                       o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Sequencer in front of the FPU: buffers tagged requests, issues one op at a time,
// waits for the FPU (with a watchdog) and returns the tagged result in request order.
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [31:0]            req_a,
    input  logic [31:0]            req_b,
    input  logic [TAG_W-1:0]       req_tag,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [31:0]            resp_result,
    output logic [TAG_W-1:0]       resp_tag,
    output logic                   resp_err,
    output logic                   fpu_valid,
    output logic [1:0]             fpu_op_sel,
    output logic [31:0]            fpu_din1,
    output logic [31:0]            fpu_din2,
    input  logic [31:0]            fpu_result,
    input  logic                   fpu_ready,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int unsigned    WDW     = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_ONE  = WDW'(1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef struct packed {
        op_e              op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } req_w_t;

    req_w_t           w_push_data;
    req_w_t           w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WDW-1:0]   w_wd_next;

    state_e           r_state;
    logic             r_fpu_valid;
    logic [1:0]       r_op_sel;
    logic [31:0]      r_din1;
    logic [31:0]      r_din2;
    logic [TAG_W-1:0] r_tag;
    logic [WDW-1:0]   r_wd;
    logic             r_resp_valid;
    logic [31:0]      r_resp_result;
    logic [TAG_W-1:0] r_resp_tag;
    logic             r_resp_err;

    assign req_ready   = !w_full;
    assign w_push      = req_valid && !w_full;
    assign w_push_data = '{op: op_e'(req_op), a: req_a, b: req_b, tag: req_tag};
    // A pop happens from IDLE, or from RESP in the same cycle the response is taken.
    assign w_pop       = !w_empty && ((r_state == IDLE) || ((r_state == RESP) && resp_ready));
    assign w_wd_next   = r_wd + WD_ONE;

    fpu_req_fifo #(
        .DEPTH (DEPTH),
        .T     (req_w_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (q_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_fpu_valid   <= 1'b0;
            r_op_sel      <= '0;
            r_din1        <= '0;
            r_din2        <= '0;
            r_tag         <= '0;
            r_wd          <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_result <= '0;
            r_resp_tag    <= '0;
            r_resp_err    <= 1'b0;
        end else begin
            r_fpu_valid <= w_pop;
            if (w_pop) begin
                r_op_sel <= w_head.op;
                r_din1   <= w_head.a;
                r_din2   <= w_head.b;
                r_tag    <= w_head.tag;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_wd    <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // A ready in the final watchdog cycle still wins over the abort.
                    if (fpu_ready) begin
                        r_resp_result <= fpu_result;
                        r_resp_err    <= 1'b0;
                        r_resp_tag    <= r_tag;
                        r_resp_valid  <= 1'b1;
                        r_state       <= RESP;
                    end else if (w_wd_next == WD_LAST) begin
                        r_resp_result <= QNAN;
                        r_resp_err    <= 1'b1;
                        r_resp_tag    <= r_tag;
                        r_resp_valid  <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_wd <= w_wd_next;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= w_pop ? ISSUE : IDLE;
                    end
                end
            endcase
        end
    end

    assign fpu_valid   = r_fpu_valid;
    assign fpu_op_sel  = r_op_sel;
    assign fpu_din1    = r_din1;
    assign fpu_din2    = r_din2;
    assign resp_valid  = r_resp_valid;
    assign resp_result = r_resp_result;
    assign resp_tag    = r_resp_tag;
    assign resp_err    = r_resp_err;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomised bench for fpu_issue_ctrl with a transaction-level scoreboard and a behavioural FPU.
module tb_fpu_issue_ctrl;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned TIMEOUT = 64;
    localparam logic [31:0] QNAN_V  = 32'h7FC00000;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_result;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;
    logic             fpu_valid;
    logic [1:0]       fpu_op_sel;
    logic [31:0]      fpu_din1;
    logic [31:0]      fpu_din2;
    logic [31:0]      fpu_result;
    logic             fpu_ready;
    logic [2:0]       q_count;

    always #5 clk = ~clk;

    fpu_issue_ctrl #(
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_tag     (req_tag),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_tag    (resp_tag),
        .resp_err    (resp_err),
        .fpu_valid   (fpu_valid),
        .fpu_op_sel  (fpu_op_sel),
        .fpu_din1    (fpu_din1),
        .fpu_din2    (fpu_din2),
        .fpu_result  (fpu_result),
        .fpu_ready   (fpu_ready),
        .q_count     (q_count)
    );

    typedef struct {
        logic [1:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } txn_t;

    txn_t        iss_q[$];
    txn_t        rsp_q[$];
    txn_t        m_t;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          n_iss = 0;
    int          n_resp = 0;
    int          n_err_resp = 0;
    int          max_q = 0;
    bit          saw_full = 1'b0;
    int          lat_fixed = 0;
    int          cur_lat = 0;
    int          issue_cyc = 0;
    int          resp_first_cyc = 0;
    int          acc_cyc = 0;
    bit          outstanding = 1'b0;
    bit          bp = 1'b0;
    bit          in_resp = 1'b0;
    bit          prev_hs = 1'b0;
    bit          e_err;
    logic [1:0]  held_op;
    logic [31:0] held_a;
    logic [31:0] held_b;
    logic [36:0] prev_resp;
    logic [31:0] last_res;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stand-in FPU: the result is an arbitrary function of the operands, exact for the directed values.
    function automatic logic [31:0] fpu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 2'b00 && a == 32'h3FC00000 && b == 32'h40100000) return 32'h40700000;
        if (op == 2'b10 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (op == 2'b11 && a == 32'h3F800000 && b == 32'h40800000) return 32'h3E800000;
        return {a[31:16] ^ b[15:0], a[15:0] + b[31:16]} ^ {30'd0, op};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        bit          pend = 1'b0;
        int          cd = 0;
        logic [1:0]  p_op = '0;
        logic [31:0] p_a = '0;
        logic [31:0] p_b = '0;
        fpu_ready  = 1'b0;
        fpu_result = '0;
        forever begin
            @(posedge clk);
            #1;
            fpu_ready  = 1'b0;
            fpu_result = $urandom();
            if (!reset) begin
                pend = 1'b0;
            end else if (fpu_valid) begin
                pend = 1'b1;
                p_op = fpu_op_sel;
                p_a  = fpu_din1;
                p_b  = fpu_din2;
                if (lat_fixed > 0) cd = lat_fixed;
                else cd = ($urandom_range(0, 19) == 0) ? 200 : int'($urandom_range(1, 8));
                cur_lat = cd;
            end else if (pend) begin
                cd--;
                if (cd == 0) begin
                    fpu_ready  = 1'b1;
                    fpu_result = fpu_fn(p_op, p_a, p_b);
                    pend       = 1'b0;
                end
            end
        end
    end

    initial begin
        resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            resp_ready = bp ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (prev_hs) check_eq("resp_drop", 64'(resp_valid), 64'd0);
            prev_hs = 1'b0;
            if (fpu_valid) begin
                check_eq("issue_overlap", 64'(outstanding), 64'd0);
                check_eq("issue_queue", 64'(iss_q.size() > 0), 64'd1);
                if (iss_q.size() > 0) begin
                    m_t = iss_q.pop_front();
                    check_eq("issue_op", 64'(fpu_op_sel), 64'(m_t.op));
                    check_eq("issue_din", {fpu_din1, fpu_din2}, {m_t.a, m_t.b});
                end
                n_iss++;
                outstanding = 1'b1;
                held_op     = fpu_op_sel;
                held_a      = fpu_din1;
                held_b      = fpu_din2;
                issue_cyc   = cyc;
            end else if (n_iss > 0) begin
                check_eq("hold_op", 64'(fpu_op_sel), 64'(held_op));
                check_eq("hold_din", {fpu_din1, fpu_din2}, {held_a, held_b});
            end
            check_eq("q_count", 64'(q_count), 64'(n_acc - n_iss));
            check_eq("req_ready", 64'(req_ready), 64'((n_acc - n_iss) < int'(DEPTH)));
            if (int'(q_count) > max_q) max_q = int'(q_count);
            if (!req_ready) saw_full = 1'b1;
            if (resp_valid) begin
                if (!in_resp) begin
                    resp_first_cyc = cyc;
                    e_err = (cur_lat > int'(TIMEOUT) - 1);
                    check_eq("resp_queue", 64'(rsp_q.size() > 0), 64'd1);
                    if (rsp_q.size() > 0) begin
                        m_t = rsp_q[0];
                        check_eq("resp_tag", 64'(resp_tag), 64'(m_t.tag));
                        check_eq("resp_err", 64'(resp_err), 64'(e_err));
                        check_eq("resp_result", 64'(resp_result),
                                 64'(e_err ? QNAN_V : fpu_fn(m_t.op, m_t.a, m_t.b)));
                        check_eq("resp_latency", 64'(cyc - issue_cyc),
                                 64'(e_err ? int'(TIMEOUT) : cur_lat + 1));
                    end
                    in_resp   = 1'b1;
                    prev_resp = {resp_result, resp_tag, resp_err};
                end else begin
                    check_eq("resp_hold", 64'({resp_result, resp_tag, resp_err}), 64'(prev_resp));
                end
                last_res = resp_result;
                if (resp_ready) begin
                    if (rsp_q.size() > 0) void'(rsp_q.pop_front());
                    n_resp++;
                    if (resp_err) n_err_resp++;
                    outstanding = 1'b0;
                    in_resp     = 1'b0;
                    prev_hs     = 1'b1;
                end
            end
        end
    end

    task automatic push_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] tag);
        txn_t t;
        bit   got = 1'b0;
        t = '{op: op, a: a, b: b, tag: tag};
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got     = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            if (got) begin
                iss_q.push_back(t);
                rsp_q.push_back(t);
                n_acc++;
            end
            #1;
        end
        check_eq("push_accept", 64'(got), 64'd1);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        bit done = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (rsp_q.size() == 0 && !outstanding && n_acc == n_iss) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check_eq("drain", 64'(done), 64'd1);
    endtask

    task automatic check_reset_outs(input string p);
        check_eq({p, "_fpu_valid"}, 64'(fpu_valid), 64'd0);
        check_eq({p, "_fpu_op_sel"}, 64'(fpu_op_sel), 64'd0);
        check_eq({p, "_fpu_din"}, {fpu_din1, fpu_din2}, 64'd0);
        check_eq({p, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check_eq({p, "_resp_fields"}, 64'({resp_result, resp_tag, resp_err}), 64'd0);
        check_eq({p, "_req_ready"}, 64'(req_ready), 64'd1);
        check_eq({p, "_q_count"}, 64'(q_count), 64'd0);
    endtask

    initial begin
        int a0;
        int e0;
        int r0;
        bit got;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outs("rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);

        // single add, L=4: response 7 cycles after accept
        lat_fixed = 4;
        push_req(2'b00, 32'h3FC00000, 32'h40100000, 4'd3);
        a0 = acc_cyc;
        wait_drain(200);
        check_eq("add_accept_to_resp", 64'(resp_first_cyc - a0), 64'd7);
        check_eq("add_result", 64'(last_res), 64'h40700000);

        // queue fill behind a slow FPU
        lat_fixed = 30;
        max_q     = 0;
        saw_full  = 1'b0;
        for (int i = 0; i < 5; i++) push_req(2'b01, $urandom(), $urandom(), TAG_W'(i));
        idle(2);
        check_eq("fill_max_q", 64'(max_q), 64'd4);
        check_eq("fill_saw_full", 64'(saw_full), 64'd1);
        wait_drain(2000);

        // mixed ops
        lat_fixed = 2;
        push_req(2'b10, 32'h40000000, 32'h40400000, 4'd9);
        wait_drain(200);
        check_eq("mul_op_sel", 64'(held_op), 64'd2);
        check_eq("mul_result", 64'(last_res), 64'h40C00000);
        push_req(2'b11, 32'h3F800000, 32'h40800000, 4'd10);
        wait_drain(200);
        check_eq("div_op_sel", 64'(held_op), 64'd3);
        check_eq("div_result", 64'(last_res), 64'h3E800000);

        // response backpressure
        lat_fixed = 1;
        bp        = 1'b1;
        idle(1);
        push_req(2'b00, $urandom(), $urandom(), 4'd5);
        push_req(2'b01, $urandom(), $urandom(), 4'd6);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (resp_valid) got = 1'b1;
            else idle(1);
        end
        check_eq("bp_resp_seen", 64'(got), 64'd1);
        a0 = n_acc;
        e0 = n_iss;
        push_req(2'b10, $urandom(), $urandom(), 4'd11);
        push_req(2'b11, $urandom(), $urandom(), 4'd12);
        idle(8);
        check_eq("bp_still_valid", 64'(resp_valid), 64'd1);
        check_eq("bp_no_issue", 64'(n_iss - e0), 64'd0);
        check_eq("bp_accepts", 64'(n_acc - a0), 64'd2);
        bp = 1'b0;
        wait_drain(500);

        // watchdog abort, then a normal op
        lat_fixed = 1000;
        e0 = n_err_resp;
        a0 = n_iss;
        push_req(2'b11, $urandom(), $urandom(), 4'd7);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (n_iss > a0) got = 1'b1;
            else idle(1);
        end
        check_eq("to_issue_seen", 64'(got), 64'd1);
        lat_fixed = 2;
        push_req(2'b00, $urandom(), $urandom(), 4'd8);
        wait_drain(500);
        check_eq("to_err_count", 64'(n_err_resp - e0), 64'd1);

        // random traffic
        lat_fixed = 0;
        for (int i = 0; i < 150; i++) begin
            push_req(2'($urandom_range(0, 3)), $urandom(), $urandom(), TAG_W'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 4)));
        end
        wait_drain(20000);

        // async reset while waiting on the FPU with two entries queued
        lat_fixed = 1000;
        for (int i = 0; i < 3; i++) push_req(2'b00, $urandom(), $urandom(), TAG_W'(i + 1));
        idle(3);
        check_eq("pre_rst_q_count", 64'(q_count), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outs("mid_rst");
        iss_q.delete();
        rsp_q.delete();
        n_acc       = 0;
        n_iss       = 0;
        outstanding = 1'b0;
        in_resp     = 1'b0;
        prev_hs     = 1'b0;
        r0          = n_resp;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b1;
        lat_fixed = 2;
        idle(30);
        check_eq("mid_rst_no_resp", 64'(n_resp - r0), 64'd0);
        push_req(2'b01, $urandom(), $urandom(), 4'd14);
        wait_drain(200);
        check_eq("post_rst_resp", 64'(n_resp - r0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish expected finish before limit");
        $fatal(1, "simulation time limit reached");
    end

endmodule
